// File: rtl/fft_addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// fft_addr_gen_pkg
// Shared FFT parameters and helpers. The butterfly datapath (butterfly_unit)
// and the address generator both take their default sizes from here, so the
// write-back latency seen by the address generator always matches the
// butterfly pipeline.
//   DEF_LOG2N    : log2 of the transform size N
//   DEF_BFLY_LAT : butterfly input-to-output latency in cycles
//   DEF_N        : N = 2**DEF_LOG2N
//   DEF_WB_LAT   : read-to-write-back distance = 1 (RAM read) + butterfly
// -----------------------------------------------------------------------------
package fft_addr_gen_pkg;

  localparam int DEF_LOG2N    = 4;
  localparam int DEF_BFLY_LAT = 3;
  localparam int DEF_N        = 1 << DEF_LOG2N;
  localparam int DEF_WB_LAT   = 1 + DEF_BFLY_LAT;
  localparam int STAGE_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int unsigned wb_lat_of(input int unsigned bfly_lat);
    return 32'd1 + bfly_lat;
  endfunction

  // Pair index k with bit s cleared-in: the upper bits of k move up by one
  // position and bit s of the address becomes 0, giving the 'a' element.
  function automatic int unsigned pair_a(input int unsigned k, input int unsigned s);
    int unsigned low_mask;
    low_mask = (32'd1 << s) - 32'd1;
    return ((k >> s) << (s + 32'd1)) | (k & low_mask);
  endfunction

  // 'b' element sits exactly half = 2**s above 'a'.
  function automatic int unsigned pair_b(input int unsigned k, input int unsigned s);
    return pair_a(k, s) + (32'd1 << s);
  endfunction

  // Twiddle index: position inside the butterfly group, scaled to the
  // N/2-entry twiddle ROM.
  function automatic int unsigned tw_idx(input int unsigned k, input int unsigned s,
                                         input int unsigned log2n);
    int unsigned low_mask;
    low_mask = (32'd1 << s) - 32'd1;
    return (k & low_mask) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/fft_addr_gen_if.sv
// -----------------------------------------------------------------------------
// fft_addr_gen_if
// Control/address bus between an FFT sequencer user (master) and the address
// generator (slave).
//   i_start                     : begin a full N-point transform
//   i_hold                      : suppress read issue (only with FFT_HOLD_EN)
//   o_busy / o_done             : transform in progress / completion pulse
//   o_rd_en, o_rd_addr_a/b      : butterfly read pair
//   o_tw_addr                   : twiddle ROM index for the pair being read
//   o_wr_en, o_wr_addr_a/b      : write-back pair
//   o_stage                     : current stage index
// Optional feature macro: FFT_HOLD_EN.
// -----------------------------------------------------------------------------
interface fft_addr_gen_if
  import fft_addr_gen_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N
);

  logic                 i_start;
`ifdef FFT_HOLD_EN
  logic                 i_hold;
`endif
  logic                 o_busy;
  logic                 o_done;
  logic                 o_rd_en;
  logic [LOG2N-1:0]     o_rd_addr_a;
  logic [LOG2N-1:0]     o_rd_addr_b;
  logic [LOG2N-2:0]     o_tw_addr;
  logic                 o_wr_en;
  logic [LOG2N-1:0]     o_wr_addr_a;
  logic [LOG2N-1:0]     o_wr_addr_b;
  logic [STAGE_W-1:0]   o_stage;

`ifdef FFT_HOLD_EN
  modport master (
    output i_start, i_hold,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );
  modport slave (
    input  i_start, i_hold,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );
`else
  modport master (
    output i_start,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );
  modport slave (
    input  i_start,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
  );
`endif

endinterface

// File: rtl/fft_wb_delay.sv
// -----------------------------------------------------------------------------
// fft_wb_delay
// DEPTH-deep shift register carrying the read pair (valid + both addresses)
// forward to the write-back point. It shifts every cycle; a cycle with no
// read enters as a bubble.
//   clk, rst            : clock, asynchronous active-low clear
//   i_valid, i_addr_a/b : read pair entering the pipeline
//   o_valid, o_addr_a/b : write-back pair leaving the pipeline
//   o_pending           : a valid entry is still upstream of the output stage,
//                         i.e. more writes will follow the current cycle
// -----------------------------------------------------------------------------
module fft_wb_delay #(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic          o_valid,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b,
  output logic          o_pending
);

  logic          r_valid  [DEPTH];
  logic [AW-1:0] r_addr_a [DEPTH];
  logic [AW-1:0] r_addr_b [DEPTH];

  // NOTE: every pipeline entry, addresses included, is cleared on reset so an
  // in-flight pair can never surface as a write after reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_addr_a[i] <= '0;
        r_addr_b[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, which is what makes this a shift register.
      r_valid[0]  <= i_valid;
      r_addr_a[0] <= i_valid ? i_addr_a : '0;
      r_addr_b[0] <= i_valid ? i_addr_b : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_addr_a[i] <= r_addr_a[i-1];
        r_addr_b[i] <= r_addr_b[i-1];
      end
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_addr_a = r_addr_a[DEPTH-1];
  assign o_addr_b = r_addr_b[DEPTH-1];

  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      o_pending = o_pending | r_valid[i];
    end
  end

endmodule

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
// In-place radix-2 FFT address generator. For each stage s = 0..LOG2N-1 it
// issues the N/2 butterfly read pairs with their twiddle index, then drains
// the write-back pipeline before starting the next stage so no stage reads an
// element the previous stage has not yet written.
//   clk        : sole clock
//   rst        : asynchronous active-low reset
//   bus        : fft_addr_gen_if.slave (start/hold in; status, read, twiddle,
//                write-back and stage out)
// Parameters: LOG2N (2..10), BFLY_LAT; defaults come from fft_addr_gen_pkg.
// Optional feature macro: FFT_HOLD_EN adds i_hold, which freezes read issue
// while running. Without it the generator never stalls.
// -----------------------------------------------------------------------------
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int LOG2N    = DEF_LOG2N,
  parameter int BFLY_LAT = DEF_BFLY_LAT
) (
  input  logic             clk,
  input  logic             rst,
  fft_addr_gen_if.slave    bus
);

  localparam int N      = 1 << LOG2N;
  localparam int WB_LAT = int'(wb_lat_of(BFLY_LAT));
  localparam int KW     = LOG2N - 1;

  localparam logic [KW-1:0]      K_LAST = KW'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KW-1:0]        r_k;
  logic [KW-1:0]        w_k_nxt;
  logic [STAGE_W-1:0]   r_s;
  logic [STAGE_W-1:0]   w_s_nxt;

  logic                 w_hold;
  logic                 w_issue;
  logic                 w_pending;
  logic [LOG2N-1:0]     w_rd_a;
  logic [LOG2N-1:0]     w_rd_b;
  logic [KW-1:0]        w_tw;
  logic                 w_wr_en;
  logic [LOG2N-1:0]     w_wr_a;
  logic [LOG2N-1:0]     w_wr_b;

`ifdef FFT_HOLD_EN
  assign w_hold = bus.i_hold;
`else
  assign w_hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_s     <= w_s_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case statement leaves it unassigned (which would infer a latch).
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    w_issue     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = ST_RUN;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end

      ST_RUN: begin
        if (!w_hold) begin
          w_issue = 1'b1;
          if (r_k == K_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end

      // Leave when only the output stage can still hold a write: that write
      // completes this cycle, so the next stage's first read lands one cycle
      // after the previous stage's last write.
      ST_DRAIN: begin
        if (!w_pending) begin
          if (r_s == S_LAST) begin
            w_state_nxt = ST_DONE;
            w_s_nxt     = '0;
          end else begin
            w_state_nxt = ST_RUN;
            w_s_nxt     = r_s + STAGE_W'(1);
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read pair and twiddle for the current (k, s), forced to zero when idle.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    w_tw   = '0;
    if (w_issue) begin
      w_rd_a = LOG2N'(pair_a(32'(r_k), 32'(r_s)));
      w_rd_b = LOG2N'(pair_b(32'(r_k), 32'(r_s)));
      w_tw   = KW'(tw_idx(32'(r_k), 32'(r_s), 32'(LOG2N)));
    end
  end

  fft_wb_delay #(
    .AW    (LOG2N),
    .DEPTH (WB_LAT)
  ) u_wb_delay (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_issue),
    .i_addr_a  (w_rd_a),
    .i_addr_b  (w_rd_b),
    .o_valid   (w_wr_en),
    .o_addr_a  (w_wr_a),
    .o_addr_b  (w_wr_b),
    .o_pending (w_pending)
  );

  assign bus.o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.o_done      = (r_state == ST_DONE);
  assign bus.o_rd_en     = w_issue;
  assign bus.o_rd_addr_a = w_rd_a;
  assign bus.o_rd_addr_b = w_rd_b;
  assign bus.o_tw_addr   = w_tw;
  assign bus.o_wr_en     = w_wr_en;
  assign bus.o_wr_addr_a = w_wr_a;
  assign bus.o_wr_addr_b = w_wr_b;
  assign bus.o_stage     = r_s;

endmodule

// File: tb/tb_fft_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_addr_gen
// Self-checking bench for fft_addr_gen with LOG2N=3, BFLY_LAT=3. A reference
// model builds the expected cycle-by-cycle trace of a transform from the
// butterfly schedule (pairs per stage, read-to-write distance, stage drain),
// and every output is compared against it each cycle.
// Optional feature macro: FFT_HOLD_EN (enables the hold scenarios).
// -----------------------------------------------------------------------------
module tb_fft_addr_gen;
  import fft_addr_gen_pkg::*;

  localparam int LOG2N    = 3;
  localparam int BFLY_LAT = 3;
  localparam int N        = 1 << LOG2N;
  localparam int NP       = N / 2;
  localparam int WB_LAT   = 1 + BFLY_LAT;
  localparam int MAXC     = 256;

  logic clk = 1'b0;
  logic rst;

  fft_addr_gen_if #(.LOG2N(LOG2N)) bus ();

  fft_addr_gen #(
    .LOG2N    (LOG2N),
    .BFLY_LAT (BFLY_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected trace, indexed by cycle relative to the i_start cycle.
  bit e_rd    [MAXC];
  bit e_wr    [MAXC];
  bit e_busy  [MAXC];
  bit e_done  [MAXC];
  int e_ra    [MAXC];
  int e_rb    [MAXC];
  int e_tw    [MAXC];
  int e_wa    [MAXC];
  int e_wb    [MAXC];
  int e_stage [MAXC];
  bit hold_pat  [MAXC];
  bit start_pat [MAXC];
  int t_done;

  // Observed read pairs per stage, for address-coverage checks.
  int touch  [LOG2N][N];
  int obs_a  [LOG2N][NP];
  int obs_b  [LOG2N][NP];
  int obs_tw [LOG2N][NP];
  int rd_cnt [LOG2N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Schedule: stage s issues NP pairs, skipping held cycles; each read is
  // written back WB_LAT cycles later; the next stage begins the cycle after
  // the last write; done follows the final stage's last write.
  task automatic build_model();
    int t, k, half, first, last_rd;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_ra[c] = 0; e_rb[c] = 0; e_tw[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
      e_stage[c] = 0;
    end
    t = 1;
    for (int s = 0; s < LOG2N; s++) begin
      half    = 2 ** s;
      first   = t;
      last_rd = t;
      k       = 0;
      while (k < NP) begin
        if (hold_pat[t]) begin
          t++;
        end else begin
          e_rd[t]          = 1;
          e_ra[t]          = (k / half) * 2 * half + (k % half);
          e_rb[t]          = e_ra[t] + half;
          e_tw[t]          = (k % half) * (2 ** (LOG2N - 1 - s));
          e_wr[t + WB_LAT] = 1;
          e_wa[t + WB_LAT] = e_ra[t];
          e_wb[t + WB_LAT] = e_rb[t];
          last_rd = t;
          k++;
          t++;
        end
      end
      for (int c = first; c <= last_rd + WB_LAT; c++) begin
        e_busy[c]  = 1;
        e_stage[c] = s;
      end
      t = last_rd + WB_LAT + 1;
    end
    t_done = t;
    e_done[t_done] = 1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      hold_pat[c]  = 0;
      start_pat[c] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},  32'(bus.o_busy), 0);
    check({tag, " done"},  32'(bus.o_done), 0);
    check({tag, " rd_en"}, 32'(bus.o_rd_en), 0);
    check({tag, " rd_a"},  32'(bus.o_rd_addr_a), 0);
    check({tag, " rd_b"},  32'(bus.o_rd_addr_b), 0);
    check({tag, " tw"},    32'(bus.o_tw_addr), 0);
    check({tag, " wr_en"}, 32'(bus.o_wr_en), 0);
    check({tag, " wr_a"},  32'(bus.o_wr_addr_a), 0);
    check({tag, " wr_b"},  32'(bus.o_wr_addr_b), 0);
    check({tag, " stage"}, 32'(bus.o_stage), 0);
  endtask

  // Entered 1 time unit after a clock edge with the DUT idle; that cycle is
  // cycle 0 (i_start high). Runs cycles 0..last_c, or through two idle cycles
  // after done when last_c < 0. Returns 1 time unit after the next edge.
  task automatic run_transform(input string tag, input int last_c);
    int lc, st;
    string ct;
    lc = (last_c < 0) ? t_done + 2 : last_c;
    for (int s = 0; s < LOG2N; s++) begin
      rd_cnt[s] = 0;
      for (int a = 0; a < N; a++) touch[s][a] = 0;
    end
    for (int c = 0; c <= lc; c++) begin
      bus.i_start = (c == 0) ? 1'b1 : start_pat[c];
`ifdef FFT_HOLD_EN
      bus.i_hold = hold_pat[c];
`endif
      #1;
      ct = $sformatf("%s c%0d", tag, c);
      check({ct, " busy"},  32'(bus.o_busy), 32'(e_busy[c]));
      check({ct, " done"},  32'(bus.o_done), 32'(e_done[c]));
      check({ct, " rd_en"}, 32'(bus.o_rd_en), 32'(e_rd[c]));
      check({ct, " rd_a"},  32'(bus.o_rd_addr_a), e_ra[c]);
      check({ct, " rd_b"},  32'(bus.o_rd_addr_b), e_rb[c]);
      check({ct, " tw"},    32'(bus.o_tw_addr), e_tw[c]);
      check({ct, " wr_en"}, 32'(bus.o_wr_en), 32'(e_wr[c]));
      check({ct, " wr_a"},  32'(bus.o_wr_addr_a), e_wa[c]);
      check({ct, " wr_b"},  32'(bus.o_wr_addr_b), e_wb[c]);
      check({ct, " stage"}, 32'(bus.o_stage), e_stage[c]);
      if (bus.o_rd_en === 1'b1) begin
        st = int'(bus.o_stage);
        if (st < LOG2N) begin
          if (rd_cnt[st] < NP) begin
            obs_a[st][rd_cnt[st]]  = int'(bus.o_rd_addr_a);
            obs_b[st][rd_cnt[st]]  = int'(bus.o_rd_addr_b);
            obs_tw[st][rd_cnt[st]] = int'(bus.o_tw_addr);
            rd_cnt[st]++;
          end
          touch[st][int'(bus.o_rd_addr_a)]++;
          touch[st][int'(bus.o_rd_addr_b)]++;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;
`ifdef FFT_HOLD_EN
    bus.i_hold = 1'b0;
`endif
  endtask

  task automatic check_coverage(input string tag);
    for (int s = 0; s < LOG2N; s++) begin
      for (int a = 0; a < N; a++) begin
        check($sformatf("%s touch s%0d addr%0d", tag, s, a), touch[s][a], 1);
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check_all_zero($sformatf("%s idle%0d", tag, i));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int gap;
    rst         = 1'b0;
    bus.i_start = 1'b0;
`ifdef FFT_HOLD_EN
    bus.i_hold  = 1'b0;
`endif
    clear_stim();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Plain transform: reads 1-4, 9-12, 17-20; writes 5-8, 13-16, 21-24; done 25.
    clear_stim();
    build_model();
    run_transform("basic", -1);
    check_coverage("basic");
    check("basic s0k0 a",  obs_a[0][0], 0);
    check("basic s0k0 b",  obs_b[0][0], 1);
    check("basic s0k0 tw", obs_tw[0][0], 0);
    check("basic s1k1 a",  obs_a[1][1], 1);
    check("basic s1k1 b",  obs_b[1][1], 3);
    check("basic s1k1 tw", obs_tw[1][1], 2);
    check("basic s2k3 a",  obs_a[2][3], 3);
    check("basic s2k3 b",  obs_b[2][3], 7);
    check("basic s2k3 tw", obs_tw[2][3], 3);

    // i_start during a transform has no effect.
    clear_stim();
    start_pat[10] = 1;
    build_model();
    run_transform("restart", -1);

`ifdef FFT_HOLD_EN
    // Hold in cycles 2-3 of stage 0: reads 1,4,5,6; writes 5,8,9,10; stage 1 at 11.
    clear_stim();
    hold_pat[2] = 1;
    hold_pat[3] = 1;
    build_model();
    run_transform("hold", -1);
    check_coverage("hold");
`endif

    // Reset in cycle 14 of a transform: outputs drop at once, nothing follows.
    clear_stim();
    build_model();
    run_transform("rstmid", 13);
    rst = 1'b0;
    #1;
    check_all_zero("rstmid asserted");
    @(posedge clk);
    #1;
    check_all_zero("rstmid held");
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles("rstmid after", 30);

    clear_stim();
    build_model();
    run_transform("post_rst", -1);
    check_coverage("post_rst");

    // Randomized transforms: stray i_start pulses and (with hold) random stalls.
    for (int tr = 0; tr < 6; tr++) begin
      gap = int'($urandom_range(0, 4));
      idle_cycles($sformatf("rnd%0d gap", tr), gap);
      clear_stim();
`ifdef FFT_HOLD_EN
      for (int c = 0; c < 100; c++) hold_pat[c] = ($urandom_range(0, 3) == 0);
`endif
      build_model();
      for (int c = 1; c <= t_done; c++) start_pat[c] = ($urandom_range(0, 7) == 0);
      run_transform($sformatf("rnd%0d", tr), -1);
      check_coverage($sformatf("rnd%0d", tr));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
